// File: rtl/dispatcher_pkg.sv
// Widths and the result packet shared by the dispatcher, tag_fifo and the CDB broadcaster.
package dispatcher_pkg;

  localparam int TAG_WIDTH  = 6;
  localparam int DATA_WIDTH = 32;
  localparam int REG_WIDTH  = 5;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
    logic [REG_WIDTH-1:0]  rd;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_broadcaster_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping at N-1.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic                 en,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  localparam int PW = $clog2(N);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // ptr + k stays below 2N, so a single conditional subtract is enough to wrap
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      idx = sum[PW-1:0];
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// Collects execution-unit results into one-entry slots and broadcasts one per cycle on the CDB.
module cdb_broadcaster
  import dispatcher_pkg::*;
#(
  parameter int NUM_UNITS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_UNITS-1:0]                 eu_valid,
  input  logic [NUM_UNITS*TAG_WIDTH-1:0]       eu_tag,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0]      eu_data,
  input  logic [NUM_UNITS*REG_WIDTH-1:0]       eu_rd,
  output logic [NUM_UNITS-1:0]                 eu_ready,
  input  logic                                 tf_full,
  output logic                                 cdb_valid,
  output logic [TAG_WIDTH-1:0]                 cdb_tag,
  output logic [DATA_WIDTH-1:0]                cdb_data,
  output logic [REG_WIDTH-1:0]                 cdb_rd,
  output logic [$clog2(NUM_UNITS+1)-1:0]       pending_cnt
);

  localparam int PTR_W = $clog2(NUM_UNITS);
  localparam int CNT_W = $clog2(NUM_UNITS+1);

  cdb_pkt_t             slot_q [NUM_UNITS];
  cdb_pkt_t             slot_d [NUM_UNITS];
  logic [NUM_UNITS-1:0] slot_valid_q, slot_valid_d;
  logic [NUM_UNITS-1:0] grant, accept;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  cdb_pkt_t             cdb_q, cdb_d;
  logic                 cdb_valid_q, cdb_valid_d;
  logic [CNT_W-1:0]     pending_q, pending_d;

  rr_arbiter #(.N(NUM_UNITS)) u_arb (
    .req (slot_valid_q),
    .en  (!tf_full),
    .ptr (rr_ptr_q),
    .gnt (grant)
  );

  // A slot being granted this cycle may refill on the same edge, keeping single-unit streams at full rate
  assign eu_ready = rst ? '0 : (~slot_valid_q | grant);
  assign accept   = eu_valid & eu_ready;

  always_comb begin
    slot_d       = slot_q;
    slot_valid_d = slot_valid_q & ~grant;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (accept[i]) begin
        slot_d[i].tag   = eu_tag[i*TAG_WIDTH +: TAG_WIDTH];
        slot_d[i].data  = eu_data[i*DATA_WIDTH +: DATA_WIDTH];
        slot_d[i].rd    = eu_rd[i*REG_WIDTH +: REG_WIDTH];
        slot_valid_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    cdb_d       = cdb_q;
    cdb_valid_d = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (grant[i]) begin
        cdb_d       = slot_q[i];
        cdb_valid_d = 1'b1;
        rr_ptr_d    = (i == NUM_UNITS-1) ? '0 : PTR_W'(i+1);
      end
    end
  end

  always_comb begin
    pending_d = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      pending_d = pending_d + CNT_W'(slot_valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        slot_q[i] <= '0;
      end
      slot_valid_q <= '0;
      rr_ptr_q     <= '0;
      cdb_q        <= '0;
      cdb_valid_q  <= 1'b0;
      pending_q    <= '0;
    end else begin
      slot_q       <= slot_d;
      slot_valid_q <= slot_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_q        <= cdb_d;
      cdb_valid_q  <= cdb_valid_d;
      pending_q    <= pending_d;
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_tag     = cdb_q.tag;
  assign cdb_data    = cdb_q.data;
  assign cdb_rd      = cdb_q.rd;
  assign pending_cnt = pending_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed-vector bench for cdb_broadcaster with hand-computed expectations.
module tb_cdb_broadcaster;

  localparam int NU = 4;
  localparam int TW = 6;
  localparam int DW = 32;
  localparam int RW = 5;

  logic              clk;
  logic              rst;
  logic [NU-1:0]     eu_valid;
  logic [NU*TW-1:0]  eu_tag;
  logic [NU*DW-1:0]  eu_data;
  logic [NU*RW-1:0]  eu_rd;
  logic [NU-1:0]     eu_ready;
  logic              tf_full;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_data;
  logic [RW-1:0]     cdb_rd;
  logic [2:0]        pending_cnt;

  int vecCount  = 0;
  int missCount = 0;

  cdb_broadcaster #(.NUM_UNITS(NU)) dut (
    .clk         (clk),
    .rst         (rst),
    .eu_valid    (eu_valid),
    .eu_tag      (eu_tag),
    .eu_data     (eu_data),
    .eu_rd       (eu_rd),
    .eu_ready    (eu_ready),
    .tf_full     (tf_full),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .cdb_rd      (cdb_rd),
    .pending_cnt (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expectation and tallies the result
  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input int unit, input logic [TW-1:0] tag,
                               input logic [DW-1:0] data, input logic [RW-1:0] rd);
    eu_valid[unit]            = 1'b1;
    eu_tag[unit*TW +: TW]     = tag;
    eu_data[unit*DW +: DW]    = data;
    eu_rd[unit*RW +: RW]      = rd;
  endtask

  task automatic clearAll;
    eu_valid = '0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic doReset;
    rst     = 1'b1;
    tf_full = 1'b0;
    clearAll();
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  task automatic checkCdb(input string name, input logic [TW-1:0] tag,
                          input logic [DW-1:0] data, input logic [RW-1:0] rd);
    checkOutput({name, "_valid"}, 64'(cdb_valid), 64'd1);
    checkOutput({name, "_tag"},   64'(cdb_tag),   64'(tag));
    checkOutput({name, "_data"},  64'(cdb_data),  64'(data));
    checkOutput({name, "_rd"},    64'(cdb_rd),    64'(rd));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    tf_full  = 1'b0;
    eu_valid = '0;
    eu_tag   = '0;
    eu_data  = '0;
    eu_rd    = '0;

    // Reset state, observed while rst is still asserted
    tick();
    tick();
    checkOutput("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    checkOutput("rst_pending", 64'(pending_cnt), 64'd0);
    checkOutput("rst_ready", 64'(eu_ready), 64'h0);
    checkOutput("rst_tag", 64'(cdb_tag), 64'd0);
    checkOutput("rst_data", 64'(cdb_data), 64'd0);
    checkOutput("rst_rd", 64'(cdb_rd), 64'd0);
    rst = 1'b0;
    settle();
    checkOutput("idle_ready", 64'(eu_ready), 64'hF);

    // Single request from unit 1
    applyStimulus(1, 6'd5, 32'hDEAD_BEEF, 5'd3);
    tick();
    clearAll();
    checkOutput("single_pending1", 64'(pending_cnt), 64'd1);
    checkOutput("single_early", 64'(cdb_valid), 64'd0);
    tick();
    checkCdb("single", 6'd5, 32'hDEAD_BEEF, 5'd3);
    checkOutput("single_pending0", 64'(pending_cnt), 64'd0);
    tick();
    checkOutput("single_drop", 64'(cdb_valid), 64'd0);
    checkOutput("single_hold_tag", 64'(cdb_tag), 64'd5);

    // Contention: all four units on the same edge, pointer at 0
    doReset();
    for (int u = 0; u < NU; u++) applyStimulus(u, 6'(10+u), 32'(32'h1000+u), 5'(u+8));
    tick();
    clearAll();
    settle();
    checkOutput("cont_pending4", 64'(pending_cnt), 64'd4);
    checkOutput("cont_ready_full", 64'(eu_ready), 64'h1);
    for (int k = 0; k < NU; k++) begin
      tick();
      checkCdb($sformatf("cont%0d", k), 6'(10+k), 32'(32'h1000+k), 5'(k+8));
      checkOutput($sformatf("cont_pending_%0d", k), 64'(pending_cnt), 64'(3-k));
      if (k == 0) checkOutput("cont_ready_after0", 64'(eu_ready), 64'h3);
    end
    tick();
    checkOutput("cont_idle", 64'(cdb_valid), 64'd0);

    // Round-robin fairness after a grant to unit 2
    doReset();
    applyStimulus(2, 6'd22, 32'h22, 5'd2);
    tick();
    clearAll();
    tick();
    checkCdb("rr_u2", 6'd22, 32'h22, 5'd2);
    applyStimulus(1, 6'd21, 32'h21, 5'd1);
    applyStimulus(3, 6'd23, 32'h23, 5'd3);
    tick();
    clearAll();
    checkOutput("rr_pending2", 64'(pending_cnt), 64'd2);
    applyStimulus(0, 6'd20, 32'h20, 5'd0);
    tick();
    clearAll();
    checkCdb("rr_u3", 6'd23, 32'h23, 5'd3);
    tick();
    checkCdb("rr_u0", 6'd20, 32'h20, 5'd0);
    tick();
    checkCdb("rr_u1", 6'd21, 32'h21, 5'd1);
    tick();
    checkOutput("rr_idle", 64'(cdb_valid), 64'd0);

    // Streaming from unit 0, tags 0..7 back to back
    doReset();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 6'(k), 32'(32'h100+k), 5'(k));
      settle();
      checkOutput($sformatf("stream_ready_%0d", k), 64'(eu_ready[0]), 64'd1);
      tick();
      if (k > 0) checkCdb($sformatf("stream%0d", k-1), 6'(k-1), 32'(32'h100+k-1), 5'(k-1));
    end
    clearAll();
    tick();
    checkCdb("stream7", 6'd7, 32'h107, 5'd7);
    tick();
    checkOutput("stream_idle", 64'(cdb_valid), 64'd0);

    // tf_full stall with slots 0 and 2 occupied
    doReset();
    tf_full = 1'b1;
    applyStimulus(0, 6'd30, 32'h30, 5'd30);
    applyStimulus(2, 6'd32, 32'h32, 5'd31);
    tick();
    clearAll();
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("stall_valid_%0d", k), 64'(cdb_valid), 64'd0);
      checkOutput($sformatf("stall_pending_%0d", k), 64'(pending_cnt), 64'd2);
      checkOutput($sformatf("stall_ready_%0d", k), 64'(eu_ready), 64'hA);
      tick();
    end
    tf_full = 1'b0;
    tick();
    checkCdb("stall_u0", 6'd30, 32'h30, 5'd30);
    tick();
    checkCdb("stall_u2", 6'd32, 32'h32, 5'd31);

    // Reset mid-operation with three slots full and a grant in flight
    doReset();
    applyStimulus(0, 6'd40, 32'h40, 5'd4);
    applyStimulus(1, 6'd41, 32'h41, 5'd5);
    applyStimulus(2, 6'd42, 32'h42, 5'd6);
    tick();
    clearAll();
    rst = 1'b1;
    applyStimulus(0, 6'd50, 32'h50, 5'd7);
    settle();
    checkOutput("midrst_ready", 64'(eu_ready), 64'h0);
    tick();
    checkOutput("midrst_valid", 64'(cdb_valid), 64'd0);
    checkOutput("midrst_pending", 64'(pending_cnt), 64'd0);
    checkOutput("midrst_tag", 64'(cdb_tag), 64'd0);
    rst = 1'b0;
    clearAll();
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("midrst_quiet_%0d", k), 64'(cdb_valid), 64'd0);
      checkOutput($sformatf("midrst_empty_%0d", k), 64'(pending_cnt), 64'd0);
    end
    applyStimulus(3, 6'd45, 32'h45, 5'd9);
    tick();
    clearAll();
    tick();
    checkCdb("midrst_new", 6'd45, 32'h45, 5'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
Write-side partner of tag_fifo. Collects completion results from NUM_UNITS execution units and broadcasts at most one per cycle on the common data bus (CDB). The broadcast carries tag, data and destination register. cdb_tag/cdb_valid drive tag_fifo's cdb_tag_tf/cdb_tag_tf_valid, returning freed tags to the free pool. Each unit port has a one-entry holding slot and a valid/ready handshake; the arbiter is round-robin.

Parameters:
NUM_UNITS, 4, number of execution-unit request ports (>=2, need not be a power of 2)
TAG_WIDTH, 6, tag width (matches tag_fifo DATA_WIDTH)
DATA_WIDTH, 32, result data width
REG_WIDTH, 5, architectural destination register index width

Ports:
clk  in  1  clock
rst  in  1  reset
eu_valid  in  NUM_UNITS  per-unit completion request
eu_tag  in  NUM_UNITS*TAG_WIDTH  per-unit tag, unit i at [i*TAG_WIDTH +: TAG_WIDTH]
eu_data  in  NUM_UNITS*DATA_WIDTH  per-unit result data
eu_rd  in  NUM_UNITS*REG_WIDTH  per-unit destination register
eu_ready  out  NUM_UNITS  per-unit accept
tf_full  in  1  tag_fifo full flag (ff_tf); blocks broadcast
cdb_valid  out  1  broadcast valid (to cdb_tag_tf_valid)
cdb_tag  out  TAG_WIDTH  broadcast tag (to cdb_tag_tf)
cdb_data  out  DATA_WIDTH  broadcast data
cdb_rd  out  REG_WIDTH  broadcast destination register
pending_cnt  out  $clog2(NUM_UNITS+1)  number of occupied slots

Behaviour:
- Clock domain and reset: single clock clk. rst is synchronous and active-high.
- Reset values:
  - All slots invalid; rr_ptr=0.
  - cdb_valid=0; cdb_tag, cdb_data and cdb_rd =0.
  - pending_cnt=0.
  - eu_ready forced to 0 while rst=1.
- Reset mid-operation: slot contents and any in-flight broadcast are discarded with no CDB output. A request presented during rst is not accepted.
- Slot accept: unit i is accepted when eu_valid[i] && eu_ready[i] at a posedge. The slot loads tag/data/rd and its valid bit sets.
- eu_ready[i] = !rst && (!slot_valid[i] || grant[i]). This is combinational from slot state and grant only, never from eu_valid, so there is no loop. A unit must hold its request stable until accepted.
- grant (one-hot or zero):
  - If tf_full=1 or no slot is valid, grant=0.
  - Otherwise, grant the first valid slot searching rr_ptr, rr_ptr+1, ... with wrap from NUM_UNITS-1 to 0.
- At a posedge with grant[g]=1:
  - cdb_tag/data/rd load slot g; cdb_valid<=1.
  - slot g clears, unless eu accepts into it on the same edge; in that case the new entry replaces it and stays valid.
  - rr_ptr <= (g==NUM_UNITS-1) ? 0 : g+1.
- At a posedge with grant=0: cdb_valid<=0; cdb_tag/data/rd hold their last values; rr_ptr holds.
- Latency: request accepted at edge N, uncontested and tf_full=0 → cdb_valid high after edge N+1 for exactly one cycle per grant.
- Throughput: one broadcast per cycle overall. A single unit streaming back-to-back sustains 1/cycle.
- tf_full: stalls grants only. Slots still accept while empty; occupied slots are held intact. Broadcast resumes the cycle after tf_full falls.
- pending_cnt: registered popcount of slot valid bits after each edge.
- Tag value 0 is a legal tag; there is no reserved value.
- Broadcast order is fixed by the arbiter, not by acceptance time.

Decomposition:
- dispatcher_pkg holds:
  - TAG_WIDTH, DATA_WIDTH, REG_WIDTH constants, shared with tag_fifo and the dispatcher.
  - typedef cdb_pkt_t {tag, data, rd}, used for the slots and the output register.
- One sub-module, rr_arbiter #(N): inputs req[N], en, ptr; output one-hot gnt[N]. It is purely combinational; the pointer register lives in cdb_broadcaster.

Test Plan:
- Single request: after reset, unit 1 presents tag=5, data=0xDEAD_BEEF, rd=3 for one handshake → cdb_valid=1 for one cycle, two edges later, with tag 5/0xDEADBEEF/rd 3. pending_cnt goes 1 then 0.
- Contention: all 4 units present tags 10,11,12,13 on the same edge → broadcasts on 4 consecutive cycles in order 10,11,12,13. eu_ready is low for losers while their slots are full.
- Round-robin fairness: rr_ptr advanced past unit 2 (last grant 2), with units 1 and 3 pending → unit 3 broadcasts first, then unit 1. Unit 0 arriving meanwhile is granted before unit 1.
- Streaming: unit 0 holds eu_valid high with tags 0..7 while the other units are idle → eu_ready[0] stays 1. CDB shows tags 0..7 on 8 consecutive cycles, including tag 0.
- tf_full stall: slots 0 and 2 full, tf_full high for 3 cycles → cdb_valid=0 and slots retained (pending_cnt=2). The cycle after tf_full falls, the unit 0 tag appears, then unit 2.
- Reset mid-operation: 3 slots full, rst=1 for one edge → cdb_valid=0, pending_cnt=0, eu_ready=0 during rst. No stale tag is ever broadcast afterward; a subsequent new request is broadcast normally.
